wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Writeback-side driver for the 3-port register file write port. Merges
//  result requests from the ALU and the load/store unit into one in-order
//  queue, drains one entry per cycle onto write_enable/write_reg/wb_data,
//  and publishes a pending-write mask for the hazard unit. Sits between the
//  execute/memory stages and the register file.
// PARAMETERS
//  DEPTH   4   queue entries; power of 2, >= 2
//  DATA_W  32  result width; equals register width
// PORTS
//  clk           in   1       rising-edge clock
//  rst           in   1       synchronous reset, active-high
//  alu_valid     in   1       ALU result request
//  alu_ready     out  1       ALU request accepted this edge when valid&ready
//  alu_rd        in   5       ALU destination register
//  alu_data      in   DATA_W  ALU result
//  mem_valid     in   1       load result request
//  mem_ready     out  1       load request accepted this edge when valid&ready
//  mem_rd        in   5       load destination register
//  mem_data      in   DATA_W  load result
//  wb_stall      in   1       hold the write port; no entry is drained
//  write_enable  out  1       to reg file write_enable
//  write_reg     out  5       to reg file write_reg
//  wb_data       out  DATA_W  to reg file data_in
//  pending       out  32      bit r=1: a queued entry targets register r
//  fifo_count    out  $clog2(DEPTH)+1  number of queued entries
// BEHAVIOUR
//  - Reset (rst=1 at an edge): rd/wr pointers=0, count=0. While rst=1:
//    alu_ready=mem_ready=0, write_enable=0, pending=0. Queued entries are
//    discarded and never written, including on reset mid-drain.
//  - Storage is a circular buffer of {rd[4:0], data}. Pointers wrap modulo
//    DEPTH. full = (count==DEPTH), empty = (count==0).
//  - Acceptance, at most one request per cycle; mem has priority (older):
//      mem_ready = !rst & !full
//      alu_ready = !rst & !full & !mem_valid
//    Ready depends only on state and mem_valid, never on the pop this cycle.
//    A full queue does not accept, even if it drains in the same cycle.
//  - rd==0 request: accepted under the same ready rules but not enqueued.
//    count, pending and the write port are unaffected.
//  - Drain: pop = !empty & !wb_stall. Outputs come combinationally from the
//    head entry: write_enable=pop, write_reg=head.rd, wb_data=head.data.
//    When pop=0: write_reg=0, wb_data=0. The reg file commits at the same
//    edge that advances rd_ptr.
//  - Latency: a request accepted at edge N is at the head by the cycle after
//    N if the queue was empty. It is written at edge N+1 when wb_stall=0.
//  - Ordering: strict FIFO across both sources. Two writes to the same rd
//    commit in acceptance order; the last accepted value wins.
//  - Simultaneous push and pop (not full): both happen, count unchanged.
//    Push into empty queue with pop=0: head is valid next cycle.
//  - pending: combinational OR over all occupied entries of onehot(rd).
//    It includes the head being written this cycle. pending[0] is always 0.
//  - fifo_count: registered count, 0..DEPTH.
//  - No flush input. The pipeline never squashes after writeback request.
// TESTING
//  1 ALU rd=5, data=0xDEADBEEF, wb_stall=0 -> next cycle write_enable=1,
//    write_reg=5, wb_data=0xDEADBEEF, pending=0x20. Following cycle:
//    write_enable=0, pending=0.
//  2 Same cycle: mem rd=3/0x11 and alu rd=4/0x22 -> mem_ready=1, alu_ready=0.
//    ALU is accepted next cycle. Writes commit rd3=0x11 then rd4=0x22 on
//    consecutive cycles.
//  3 wb_stall=1, push ALU rd=1..4 -> fifo_count=4, alu_ready=mem_ready=0,
//    pending=0x1E. Drop stall -> rd1..rd4 written in 4 consecutive cycles.
//  4 ALU rd=0, data=0xFFFFFFFF -> alu_ready=1, fifo_count stays 0,
//    write_enable never asserts, pending=0.
//  5 wb_stall=1, ALU rd=7/0xA then rd=7/0xB; drop stall -> two writes in
//    order, final wb_data=0xB. pending[7] stays 1 until the second drains.
//  6 3 entries queued, rst=1 for 1 cycle -> fifo_count=0, write_enable=0,
//    pending=0. No queued entry ever appears on the write port.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and load results into one in-order queue and
// drains one entry per cycle onto the register file write port.
module wb_arbiter #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [4:0]               alu_rd,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [4:0]               mem_rd,
  input  logic [DATA_W-1:0]        mem_data,
  input  logic                     wb_stall,
  output logic                     write_enable,
  output logic [4:0]               write_reg,
  output logic [DATA_W-1:0]        wb_data,
  output logic [31:0]              pending,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [4:0]        rd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic              full, empty;
  logic              push_mem, push_alu, push, pop;
  logic [4:0]        push_rd;
  logic [DATA_W-1:0] push_data;
  logic [DEPTH-1:0]  occupied;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

  // Ready never looks at this cycle's pop, so a full queue stalls producers
  // for a cycle even when it drains.
  assign mem_ready = !rst && !full;
  assign alu_ready = !rst && !full && !mem_valid;

  assign push_mem  = mem_valid && mem_ready;
  assign push_alu  = alu_valid && alu_ready;
  assign push_rd   = push_mem ? mem_rd : alu_rd;
  assign push_data = push_mem ? mem_data : alu_data;
  // Writes to x0 are acknowledged but dropped.
  assign push      = (push_mem || push_alu) && (push_rd != 5'd0);
  assign pop       = !rst && !empty && !wb_stall;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      rd_mem[wr_ptr_q]   <= push_rd;
      data_mem[wr_ptr_q] <= push_data;
    end
  end

  always_comb begin
    occupied = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      logic [PtrW-1:0] offset;
      offset = PtrW'(i) - rd_ptr_q;
      occupied[i] = ({1'b0, offset} < count_q);
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (occupied[i]) pending[rd_mem[i]] = 1'b1;
    end
    pending[0] = 1'b0;
    if (rst) pending = '0;
  end

  always_comb begin
    write_enable = pop;
    write_reg    = '0;
    wb_data      = '0;
    if (pop) begin
      write_reg = rd_mem[rd_ptr_q];
      wb_data   = data_mem[rd_ptr_q];
    end
  end

  assign fifo_count = count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid, wb_stall;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_rd, mem_rd, write_reg;
  logic [31:0] alu_data, mem_data, wb_data, pending;
  logic        write_enable;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  wb_arbiter #(.DEPTH(4), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .wb_stall    (wb_stall),
    .write_enable(write_enable),
    .write_reg   (write_reg),
    .wb_data     (wb_data),
    .pending     (pending),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past a rising edge; inputs are driven away from the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_valid = v;
    alu_rd    = rd;
    alu_data  = d;
  endtask

  initial begin
    rst = 1'b1; alu_valid = 0; mem_valid = 0; wb_stall = 0;
    alu_rd = 0; alu_data = 0; mem_rd = 0; mem_data = 0;

    // Reset state
    step(); step(); #1;
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_we", 32'(write_enable), 32'd0);
    chk("rst_alu_ready", 32'(alu_ready), 32'd0);
    chk("rst_mem_ready", 32'(mem_ready), 32'd0);
    chk("rst_pending", pending, 32'd0);
    rst = 1'b0;

    // 1: single ALU write
    step();
    alu(1, 5'd5, 32'hDEADBEEF); #1;
    chk("t1_alu_ready", 32'(alu_ready), 32'd1);
    chk("t1_we_before", 32'(write_enable), 32'd0);
    step();
    alu(0, 0, 0); #1;
    chk("t1_we", 32'(write_enable), 32'd1);
    chk("t1_reg", 32'(write_reg), 32'd5);
    chk("t1_data", wb_data, 32'hDEADBEEF);
    chk("t1_pending", pending, 32'h20);
    chk("t1_count", 32'(fifo_count), 32'd1);
    step(); #1;
    chk("t1_we_after", 32'(write_enable), 32'd0);
    chk("t1_pending_after", pending, 32'd0);
    chk("t1_count_after", 32'(fifo_count), 32'd0);

    // 2: mem has priority over ALU
    mem_valid = 1; mem_rd = 5'd3; mem_data = 32'h11;
    alu(1, 5'd4, 32'h22); #1;
    chk("t2_mem_ready", 32'(mem_ready), 32'd1);
    chk("t2_alu_ready", 32'(alu_ready), 32'd0);
    step();
    mem_valid = 0; #1;
    chk("t2_alu_ready2", 32'(alu_ready), 32'd1);
    chk("t2_we0", 32'(write_enable), 32'd1);
    chk("t2_reg0", 32'(write_reg), 32'd3);
    chk("t2_data0", wb_data, 32'h11);
    chk("t2_pending0", pending, 32'h08);
    step();
    alu(0, 0, 0); #1;
    chk("t2_count_pushpop", 32'(fifo_count), 32'd1);
    chk("t2_we1", 32'(write_enable), 32'd1);
    chk("t2_reg1", 32'(write_reg), 32'd4);
    chk("t2_data1", wb_data, 32'h22);
    step(); #1;
    chk("t2_we_after", 32'(write_enable), 32'd0);

    // 3: fill under stall, then drain; full queue refuses a request while draining
    wb_stall = 1;
    for (int i = 1; i <= 4; i++) begin
      alu(1, 5'(i), 32'(i * 256));
      step();
    end
    alu(0, 0, 0); #1;
    chk("t3_count_full", 32'(fifo_count), 32'd4);
    chk("t3_alu_ready", 32'(alu_ready), 32'd0);
    chk("t3_mem_ready", 32'(mem_ready), 32'd0);
    chk("t3_pending", pending, 32'h1E);
    chk("t3_we_stalled", 32'(write_enable), 32'd0);
    wb_stall = 0;
    alu(1, 5'd9, 32'h999); #1;
    chk("t3_full_no_accept", 32'(alu_ready), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      chk("t3_drain_we", 32'(write_enable), 32'd1);
      chk("t3_drain_reg", 32'(write_reg), 32'(i));
      chk("t3_drain_data", wb_data, 32'(i * 256));
      step();
      alu(0, 0, 0); #1;
    end
    chk("t3_empty_we", 32'(write_enable), 32'd0);
    chk("t3_empty_count", 32'(fifo_count), 32'd0);
    chk("t3_empty_pending", pending, 32'd0);

    // 4: rd=0 is accepted but dropped
    alu(1, 5'd0, 32'hFFFFFFFF); #1;
    chk("t4_alu_ready", 32'(alu_ready), 32'd1);
    step();
    alu(0, 0, 0); #1;
    chk("t4_count", 32'(fifo_count), 32'd0);
    chk("t4_we", 32'(write_enable), 32'd0);
    chk("t4_pending", pending, 32'd0);
    step(); #1;
    chk("t4_we2", 32'(write_enable), 32'd0);

    // 5: two writes to the same register keep order
    wb_stall = 1;
    alu(1, 5'd7, 32'hA); step();
    alu(1, 5'd7, 32'hB); step();
    alu(0, 0, 0); #1;
    chk("t5_count", 32'(fifo_count), 32'd2);
    chk("t5_pending", pending, 32'h80);
    wb_stall = 0; #1;
    chk("t5_we0", 32'(write_enable), 32'd1);
    chk("t5_reg0", 32'(write_reg), 32'd7);
    chk("t5_data0", wb_data, 32'hA);
    step(); #1;
    chk("t5_pending_mid", pending, 32'h80);
    chk("t5_data1", wb_data, 32'hB);
    chk("t5_we1", 32'(write_enable), 32'd1);
    step(); #1;
    chk("t5_pending_end", pending, 32'd0);
    chk("t5_we_end", 32'(write_enable), 32'd0);

    // 6: reset discards queued entries
    wb_stall = 1;
    alu(1, 5'd10, 32'h100A); step();
    alu(1, 5'd11, 32'h100B); step();
    alu(1, 5'd12, 32'h100C); step();
    alu(0, 0, 0); #1;
    chk("t6_count", 32'(fifo_count), 32'd3);
    chk("t6_pending", pending, 32'h1C00);
    rst = 1; wb_stall = 0; #1;
    chk("t6_rst_we", 32'(write_enable), 32'd0);
    chk("t6_rst_pending", pending, 32'd0);
    chk("t6_rst_mem_ready", 32'(mem_ready), 32'd0);
    step();
    rst = 0; #1;
    chk("t6_count_after", 32'(fifo_count), 32'd0);
    chk("t6_pending_after", pending, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("t6_we_after", 32'(write_enable), 32'd0);
      step(); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
